// File: rtl/cordic_sincos_pipe.sv
// Pipelined CORDIC sine/cosine generator: quadrant fold, STAGES rotation stages, output register.
// Angles, sines and cosines are signed Q3.FRAC words; a tag, a fold flag and an error flag ride along with each sample.
module cordic_sincos_pipe #(
  parameter int WIDTH  = 21,
  parameter int STAGES = 16,
  parameter int TAG_W  = 4
) (
  input  logic               clock,
  input  logic               aclr,
  input  logic               clk_en,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   angle,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  output logic [WIDTH-1:0]   cos_out,
  output logic [WIDTH-1:0]   sin_out,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err
);

  localparam int FRAC = WIDTH - 3;
  localparam int IW   = WIDTH + 2;

  function automatic int scaled(input real v);
    return $rtoi(v * (2.0 ** FRAC) + 0.5);
  endfunction

  localparam logic signed [IW-1:0] PI_C      = IW'(scaled(3.14159265358979323846));
  localparam logic signed [IW-1:0] PI_HALF_C = IW'(scaled(1.57079632679489661923));
  localparam logic signed [IW-1:0] K_C       = IW'(scaled(0.6072529350));

  logic signed [IW-1:0] x_reg  [0:STAGES];
  logic signed [IW-1:0] y_reg  [0:STAGES];
  logic signed [IW-1:0] z_reg  [0:STAGES];
  logic signed [IW-1:0] x_next [1:STAGES];
  logic signed [IW-1:0] y_next [1:STAGES];
  logic signed [IW-1:0] z_next [1:STAGES];
  logic [TAG_W-1:0]     tag_reg [0:STAGES];
  logic [STAGES:0]      valid_reg;
  logic [STAGES:0]      neg_reg;
  logic [STAGES:0]      err_reg;

  logic signed [IW-1:0] angle_ext;
  logic signed [IW-1:0] fold_z;
  logic                 fold_neg;
  logic                 fold_err;

  // Fold into [-pi/2, pi/2]; the half-turn is undone by negating both results at the end.
  always_comb begin
    angle_ext = {{2{angle[WIDTH-1]}}, angle};
    fold_z    = angle_ext;
    fold_neg  = 1'b0;
    if (angle_ext > PI_HALF_C) begin
      fold_z   = angle_ext - PI_C;
      fold_neg = 1'b1;
    end else if (angle_ext < -PI_HALF_C) begin
      fold_z   = angle_ext + PI_C;
      fold_neg = 1'b1;
    end
    fold_err = (angle_ext > PI_C) || (angle_ext < -PI_C);
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_rot
    localparam logic signed [IW-1:0] ATAN_I = IW'(scaled($atan(1.0 / (2.0 ** gi))));
    // Sign bit of z picks the rotation direction.
    assign x_next[gi+1] = z_reg[gi][IW-1] ? x_reg[gi] + (y_reg[gi] >>> gi)
                                          : x_reg[gi] - (y_reg[gi] >>> gi);
    assign y_next[gi+1] = z_reg[gi][IW-1] ? y_reg[gi] - (x_reg[gi] >>> gi)
                                          : y_reg[gi] + (x_reg[gi] >>> gi);
    assign z_next[gi+1] = z_reg[gi][IW-1] ? z_reg[gi] + ATAN_I
                                          : z_reg[gi] - ATAN_I;
  end

  always_ff @(posedge clock) begin
    if (clk_en) begin
      x_reg[0]   <= K_C;
      y_reg[0]   <= '0;
      z_reg[0]   <= fold_z;
      tag_reg[0] <= in_tag;
      neg_reg[0] <= fold_neg;
      err_reg[0] <= fold_err;
      for (int i = 1; i <= STAGES; i++) begin
        x_reg[i]   <= x_next[i];
        y_reg[i]   <= y_next[i];
        z_reg[i]   <= z_next[i];
        tag_reg[i] <= tag_reg[i-1];
        neg_reg[i] <= neg_reg[i-1];
        err_reg[i] <= err_reg[i-1];
      end
    end
  end

  // Valid bits and the output register are the only state that reset touches.
  always_ff @(posedge clock) begin
    if (aclr) begin
      valid_reg <= '0;
      out_valid <= 1'b0;
      cos_out   <= '0;
      sin_out   <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (clk_en) begin
      valid_reg <= {valid_reg[STAGES-1:0], in_valid};
      out_valid <= valid_reg[STAGES];
      out_tag   <= tag_reg[STAGES];
      out_err   <= err_reg[STAGES];
      if (err_reg[STAGES]) begin
        cos_out <= '0;
        sin_out <= '0;
      end else if (neg_reg[STAGES]) begin
        cos_out <= WIDTH'(-x_reg[STAGES]);
        sin_out <= WIDTH'(-y_reg[STAGES]);
      end else begin
        cos_out <= WIDTH'(x_reg[STAGES]);
        sin_out <= WIDTH'(y_reg[STAGES]);
      end
    end
  end

endmodule

// File: tb/tb_cordic_sincos_pipe.sv
// Randomized scoreboard bench for cordic_sincos_pipe: a driver queues expected results,
// a monitor checks every enabled output cycle against a real-arithmetic sin/cos reference.
module tb_cordic_sincos_pipe;

  localparam int WIDTH   = 21;
  localparam int STAGES  = 16;
  localparam int TAG_W   = 4;
  localparam int LAT     = STAGES + 2;
  localparam int PI_I    = 823550;
  localparam int PIH_I   = 411775;
  localparam real SCALE  = 262144.0;
  localparam real TOL    = 24.0;

  logic             clock;
  logic             aclr;
  logic             clk_en;
  logic             in_valid;
  logic [WIDTH-1:0] angle;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic [WIDTH-1:0] cos_out;
  logic [WIDTH-1:0] sin_out;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  cordic_sincos_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clock(clock), .aclr(aclr), .clk_en(clk_en), .in_valid(in_valid),
    .angle(angle), .in_tag(in_tag), .out_valid(out_valid), .cos_out(cos_out),
    .sin_out(sin_out), .out_tag(out_tag), .out_err(out_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int ang;
    int tag;
    bit err;
    int due;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   en_cnt   = 0;
  int   n_issued = 0;

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_near(input string name, input int act, input real exp);
    real d;
    checks++;
    d = real'(act) - exp;
    if (d < 0.0) d = -d;
    if (d > TOL) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0.1f tol=%0.0f at %0t", name, act, exp, TOL, $time);
    end
  endtask

  // Drive one cycle of stimulus; queue the expected result when the sample will be captured.
  task automatic issue(input bit v, input int a, input int t, input bit en);
    exp_t e;
    @(negedge clock);
    aclr     = 1'b0;
    in_valid = v;
    angle    = a[WIDTH-1:0];
    in_tag   = t[TAG_W-1:0];
    clk_en   = en;
    if (v && en) begin
      e.ang = a;
      e.tag = t & ((1 << TAG_W) - 1);
      e.err = (a > PI_I) || (a < -PI_I);
      e.due = en_cnt + LAT;
      sb.push_back(e);
      n_issued++;
    end
  endtask

  function automatic int rand_angle();
    return int'($urandom_range(2 * PI_I)) - PI_I;
  endfunction

  // Monitor: one check set per enabled edge, frozen-output check on held edges.
  logic             en_s, rst_s;
  logic             p_valid, p_err;
  logic [WIDTH-1:0] p_cos, p_sin;
  logic [TAG_W-1:0] p_tag;
  initial begin
    p_valid = 0; p_err = 0; p_cos = 0; p_sin = 0; p_tag = 0;
    forever begin
      @(posedge clock);
      en_s  = clk_en;
      rst_s = aclr;
      #1;
      if (!rst_s && en_s) begin
        bit exp_v;
        en_cnt++;
        while (sb.size() > 0 && sb[0].due < en_cnt) void'(sb.pop_front());
        exp_v = (sb.size() > 0) && (sb[0].due == en_cnt);
        check_int("out_valid", int'(out_valid), int'(exp_v));
        if (exp_v) begin
          exp_t e;
          e = sb.pop_front();
          if (out_valid) begin
            $display("txn tag=%0d angle=%0d cos=%0d sin=%0d err=%0d", out_tag, e.ang,
                     $signed(cos_out), $signed(sin_out), out_err);
            check_int("out_tag", int'(out_tag), e.tag);
            check_int("out_err", int'(out_err), int'(e.err));
            if (e.err) begin
              check_int("cos_err_zero", int'($signed(cos_out)), 0);
              check_int("sin_err_zero", int'($signed(sin_out)), 0);
            end else begin
              check_near("cos_out", int'($signed(cos_out)), $cos(real'(e.ang) / SCALE) * SCALE);
              check_near("sin_out", int'($signed(sin_out)), $sin(real'(e.ang) / SCALE) * SCALE);
            end
          end
        end
      end else if (!rst_s) begin
        check_int("hold_valid", int'(out_valid), int'(p_valid));
        check_int("hold_cos", int'(cos_out), int'(p_cos));
        check_int("hold_sin", int'(sin_out), int'(p_sin));
        check_int("hold_tag", int'(out_tag), int'(p_tag));
        check_int("hold_err", int'(out_err), int'(p_err));
      end
      p_valid = out_valid; p_cos = cos_out; p_sin = sin_out; p_tag = out_tag; p_err = out_err;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  int dir_angles [12] = '{0, PIH_I, PIH_I + 1, -PIH_I, -PIH_I - 1, PI_I, -PI_I,
                          PI_I + 1, -PI_I - 1, 900000, -900000, 100};

  initial begin
    aclr = 1'b1; clk_en = 1'b0; in_valid = 1'b1; angle = '0; in_tag = '0;
    repeat (2) @(negedge clock);
    clk_en = 1'b1;
    repeat (2) @(negedge clock);
    check_int("rst_valid", int'(out_valid), 0);
    check_int("rst_cos", int'(cos_out), 0);
    check_int("rst_sin", int'(sin_out), 0);
    check_int("rst_tag", int'(out_tag), 0);
    check_int("rst_err", int'(out_err), 0);

    // Directed boundaries, with the first sample isolated to expose latency.
    issue(1, 0, 3, 1);
    repeat (LAT + 2) issue(0, 0, 0, 1);
    for (int i = 1; i < 12; i++) issue(1, dir_angles[i], i, 1);
    issue(1, rand_angle(), 12, 1);
    issue(1, 900000, 13, 1);
    issue(1, rand_angle(), 14, 1);

    // Back-to-back random stream with incrementing tags.
    for (int i = 0; i < 64; i++) issue(1, rand_angle(), i, 1);

    // Stream with a 5-cycle enable hold and a sample offered while held.
    for (int i = 0; i < 40; i++) begin
      if (i >= 10 && i < 15) issue(1, rand_angle(), 99, 0);
      else issue(1, rand_angle(), i, 1);
    end

    // Random bubbles and enable gaps.
    for (int i = 0; i < 60; i++) begin
      issue($urandom_range(1) == 1, rand_angle(), i, $urandom_range(3) != 0);
    end

    // Reset with samples in flight: everything in flight is discarded.
    for (int i = 0; i < 10; i++) issue(1, rand_angle(), i, 1);
    @(negedge clock);
    aclr = 1'b1; in_valid = 1'b1; clk_en = 1'b1;
    sb.delete();
    repeat (LAT + 2) issue(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) issue(1, rand_angle(), i + 5, 1);

    repeat (LAT + 4) issue(0, 0, 0, 1);
    check_int("drain_empty", sb.size(), 0);
    $display("issued=%0d", n_issued);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
